// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter slice.
//   state_t : sequencer states (IDLE, ACCESS, RESP)
//   owner_t : transaction owner encoding (OWN_I = 0, OWN_D = 1)
//   AW_DEF / DW_DEF : default address / data widths
package mem_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req[1:0] : pending requests, bit 0 = I port, bit 1 = D port
//   last     : owner served most recently (owner_t encoding)
//   winner   : selected owner (owner_t encoding); OWN_I when nothing pends
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = logic'(OWN_I);
    case (req)
      2'b01:   winner = logic'(OWN_I);
      2'b10:   winner = logic'(OWN_D);
      // tie: whoever was not served last goes next
      2'b11:   winner = ~last;
      default: winner = logic'(OWN_I);
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port data memory between instruction fetch (I)
// and load/store (D), one word access per 3 cycles, with one-cycle strobes.
//   clk, rst_n                      : clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt           : fetch request, combinational accept
//   i_done/i_rdata/i_err            : fetch completion pulse, data, misalign flag
//   d_req/d_we/d_addr/d_wdata       : load/store request (d_we=1 store)
//   d_gnt/d_done/d_rdata/d_err      : load/store accept and completion
//   mem_address/mem_writeData       : registered memory address / write data
//   mem_memoryWrite/mem_memoryRead  : registered one-cycle strobes
//   mem_readData                    : memory data, valid the cycle after read
// Build option: MEM_ARB_ALIGN_CHECK_EN enables misaligned-address rejection
// (no strobe, done pulse with err=1). Without it addresses pass unchecked and
// i_err/d_err are tied low.
//
// state  | meaning
// IDLE   | arbitrate; gnt may be issued, request latched at the edge
// ACCESS | strobe high this cycle, memory acts on the closing edge
// RESP   | read data captured at the closing edge, done pulse follows
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_memoryWrite,
  output logic          mem_memoryRead,
  input  logic [DW-1:0] mem_readData
);

  state_t        state, state_nxt;
  owner_t        last_owner, owner;
  logic          winner;
  logic          acc;
  logic          acc_we;
  logic          acc_mis;
  logic [AW-1:0] acc_addr;
  logic          rd_q;   // transaction captures mem_readData at RESP

  rr_arb2 u_rr (
    .req    ({d_req, i_req}),
    .last   (logic'(last_owner)),
    .winner (winner)
  );

  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        // no accept is reported while reset holds the sequencer
        i_gnt = rst_n & i_req & (owner_t'(winner) == OWN_I);
        d_gnt = rst_n & d_req & (owner_t'(winner) == OWN_D);
        if (i_gnt || d_gnt) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign acc      = i_gnt | d_gnt;
  assign acc_we   = d_gnt & d_we;
  assign acc_addr = d_gnt ? d_addr : i_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_owner      <= OWN_I;
      owner           <= OWN_I;
      rd_q            <= 1'b0;
      mem_address     <= '0;
      mem_writeData   <= '0;
      mem_memoryWrite <= 1'b0;
      mem_memoryRead  <= 1'b0;
      i_done          <= 1'b0;
      d_done          <= 1'b0;
      i_rdata         <= '0;
      d_rdata         <= '0;
    end else begin
      state  <= state_nxt;
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            owner           <= d_gnt ? OWN_D : OWN_I;
            rd_q            <= ~acc_we & ~acc_mis;
            mem_address     <= acc_addr;
            // I never writes, so its transactions leave write data alone
            if (d_gnt) mem_writeData <= d_wdata;
            mem_memoryWrite <= acc_we & ~acc_mis;
            mem_memoryRead  <= ~acc_we & ~acc_mis;
          end
        end
        ACCESS: begin
          mem_memoryWrite <= 1'b0;
          mem_memoryRead  <= 1'b0;
        end
        RESP: begin
          last_owner <= owner;
          if (owner == OWN_D) begin
            d_done <= 1'b1;
            if (rd_q) d_rdata <= mem_readData;
          end else begin
            i_done <= 1'b1;
            if (rd_q) i_rdata <= mem_readData;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic mis_q;

  assign acc_mis = acc_addr[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
    end else begin
      i_err <= 1'b0;
      d_err <= 1'b0;
      if (state == IDLE && acc) mis_q <= acc_mis;
      if (state == RESP) begin
        i_err <= (owner == OWN_I) & mis_q;
        d_err <= (owner == OWN_D) & mis_q;
      end
    end
  end
`else
  assign acc_mis = 1'b0;
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, i_gnt, i_done, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData, mem_readData;
  logic          mem_memoryWrite, mem_memoryRead;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memoryWrite(mem_memoryWrite), .mem_memoryRead(mem_memoryRead),
    .mem_readData(mem_readData)
  );

  // ---------------- memory environment (16 words) ----------------
  logic        mem_load;
  logic [31:0] env_mem [16];

  function automatic logic [31:0] init_word(input int k);
    if (k == 1) return 32'hDEAD_BEEF;
    return 32'hA500_0000 ^ (32'h0101_0101 * k);
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 16; k++) env_mem[k] <= init_word(k);
    end else begin
      if (mem_memoryWrite) env_mem[mem_address[5:2]] <= mem_writeData;
      if (mem_memoryRead)  mem_readData <= env_mem[mem_address[5:2]];
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] ref_mem [16];
  logic [31:0] ref_i_rdata, ref_d_rdata;
  bit          last_d;          // last served requester was D
  bit          i_pend, d_pend, d_w;
  logic [31:0] i_a, d_a, d_dat;
  bit          prev_valid, prev_own_d, prev_err;
  bit          log_en;
  bit          gnt_log [$];

  function automatic logic [31:0] rand_addr();
    int a;
    a = $urandom_range(0, 15) * 4;
    if ($urandom_range(0, 7) == 0) a += $urandom_range(1, 3);
    return 32'(a);
  endfunction

  task automatic new_i();
    i_pend = 1; i_a = rand_addr();
  endtask

  task automatic new_d();
    d_pend = 1; d_w = $urandom_range(0, 1); d_a = rand_addr(); d_dat = $urandom;
  endtask

  task automatic drive_reqs();
    i_req = i_pend; i_addr = i_a;
    d_req = d_pend; d_we = d_w; d_addr = d_a; d_wdata = d_dat;
  endtask

  // Called at a negedge where the arbiter is idle. refill: 0 winner drops its
  // request after gnt, 1 winner holds the same request, 2 winner issues a new one.
  task automatic issue(input int refill);
    bit win_d, mis, is_wr;
    logic [31:0] a, dat;
    check("i_done", i_done, prev_valid && !prev_own_d);
    check("d_done", d_done, prev_valid && prev_own_d);
    check("i_rdata", i_rdata, ref_i_rdata);
    check("d_rdata", d_rdata, ref_d_rdata);
    if (prev_valid) check(prev_own_d ? "d_err" : "i_err", prev_own_d ? d_err : i_err, prev_err);
    if (!prev_valid || prev_own_d) check("i_err_idle", i_err, 1'b0);
    prev_valid = 0;
    drive_reqs();
    #1;
    win_d = d_pend && (!i_pend || !last_d);
    check("i_gnt", i_gnt, i_pend && !win_d);
    check("d_gnt", d_gnt, win_d);
    if (log_en && i_pend && d_pend) gnt_log.push_back(d_gnt);
    if (!(i_pend || d_pend)) begin
      @(negedge clk);
      return;
    end
    a     = win_d ? d_a : i_a;
    is_wr = win_d && d_w;
    dat   = d_dat;
    mis   = ALIGN_ON && (a[1:0] != 2'b00);

    @(negedge clk);
    check("rd_strobe", mem_memoryRead, !mis && !is_wr);
    check("wr_strobe", mem_memoryWrite, !mis && is_wr);
    if (!mis) check("mem_address", mem_address, a);
    if (!mis && is_wr) check("mem_wdata", mem_writeData, dat);
    check("gnt_in_access", {i_gnt, d_gnt}, 2'b00);
    if (win_d) begin
      if (refill == 0) d_pend = 0;
      else if (refill == 2) new_d();
    end else begin
      if (refill == 0) i_pend = 0;
      else if (refill == 2) new_i();
    end
    drive_reqs();

    if (!mis) begin
      if (is_wr) ref_mem[a[5:2]] = dat;
      else if (win_d) ref_d_rdata = ref_mem[a[5:2]];
      else ref_i_rdata = ref_mem[a[5:2]];
    end
    prev_valid = 1; prev_own_d = win_d; prev_err = mis;
    last_d = win_d;

    @(negedge clk);
    check("strobes_resp", {mem_memoryRead, mem_memoryWrite}, 2'b00);
    check("gnt_in_resp", {i_gnt, d_gnt}, 2'b00);
    check("done_early", {i_done, d_done}, 2'b00);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mem_load = 1; rst_n = 0;
    i_pend = 0; d_pend = 0; d_w = 0; i_a = 0; d_a = 0; d_dat = 0;
    drive_reqs();
    for (int k = 0; k < 16; k++) ref_mem[k] = init_word(k);
    ref_i_rdata = 0; ref_d_rdata = 0; last_d = 0;
    prev_valid = 0; log_en = 0;
    repeat (3) @(negedge clk);
    check("rst_state", {mem_memoryRead, mem_memoryWrite, i_done, d_done, i_err, d_err}, 6'b0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_writeData, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    mem_load = 0; rst_n = 1;
    @(negedge clk);

    // single load from 0x04
    d_pend = 1; d_w = 0; d_a = 32'h04;
    issue(0);
    issue(0);
    check("load_deadbeef", d_rdata, 32'hDEAD_BEEF);

    // store 0x12345678 to 0x08, then fetch it back
    d_pend = 1; d_w = 1; d_a = 32'h08; d_dat = 32'h1234_5678;
    issue(0);
    i_pend = 1; i_a = 32'h08;
    issue(0);
    issue(0);
    check("fetch_after_store", i_rdata, 32'h1234_5678);

    // contention: both held for 4 grants -> D, I, D, I
    i_pend = 1; i_a = 32'h10;
    d_pend = 1; d_w = 0; d_a = 32'h14;
    log_en = 1;
    issue(1); issue(1); issue(1); issue(0);
    log_en = 0;
    check("rr_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      check("rr_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 4'b1010);
    issue(0);
    issue(0);

    // alignment: D load from 0x06
    d_pend = 1; d_w = 0; d_a = 32'h06;
    issue(0);
    issue(0);
    check("misalign_err", d_err, 1'b0);  // err pulse has ended by now

    // back-to-back D with new address after gnt
    d_pend = 1; d_w = 0; d_a = 32'h0C;
    issue(2);
    issue(0);
    issue(0);
    issue(0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) new_i();
      if (!d_pend && $urandom_range(0, 1) == 0) new_d();
      issue($urandom_range(0, 2));
    end
    i_pend = 0; d_pend = 0;
    issue(0);
    issue(0);
    issue(0);

    // reset during ACCESS of a load
    d_pend = 1; d_w = 0; d_a = 32'h04;
    drive_reqs();
    #1;
    check("rst_pre_gnt", d_gnt, 1'b1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("rst_mid_done", {i_done, d_done}, 2'b00);
    check("rst_mid_strobes", {mem_memoryRead, mem_memoryWrite}, 2'b00);
    check("rst_mid_addr", mem_address, 0);
    check("rst_mid_rdata", {i_rdata, d_rdata}, 64'h0);
    check("rst_mid_gnt", {i_gnt, d_gnt}, 2'b00);
    rst_n = 1;
    last_d = 0; ref_i_rdata = 0; ref_d_rdata = 0; prev_valid = 0;
    issue(0);
    issue(0);
    issue(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the processor's single-port, byte-addressed, big-endian 32-bit data memory. It shares the memory between the instruction-fetch port (I) and the load/store port (D), and serialises one word access at a time. It drives the memory's read/write strobes as one-cycle pulses and returns read data together with a completion pulse to the owning requester. It sits between the core's fetch and MEM stages and the `memory` block.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `i_req` input 1: fetch request pending; `i_addr` must be stable while it is high.
- `i_addr` input AW: fetch byte address.
- `i_gnt` output 1: combinational; request accepted at this edge.
- `i_done` output 1: registered one-cycle completion pulse.
- `i_rdata` output DW: registered fetch data, valid when `i_done` is high and held afterwards.
- `i_err` output 1: misalignment flag, valid with `i_done`.
- `d_req`, `d_we`, `d_addr`, `d_wdata` inputs 1/1/AW/DW: load/store request; `d_we`=1 means store.
- `d_gnt`, `d_done`, `d_rdata`, `d_err` outputs 1/1/DW/1: same meaning as the I-port equivalents.
- `mem_address` output AW: memory address, registered.
- `mem_writeData` output DW: memory write data, registered.
- `mem_memoryWrite`, `mem_memoryRead` outputs 1: registered one-cycle strobes.
- `mem_readData` input DW: memory read data, valid the cycle after the read edge.

## Operation
- FSM states, held in `state`:
  - IDLE → ACCESS on any accepted request.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Accept: in IDLE, `x_gnt` = `x_req` & (winner is x). At that edge:
  - latch address, wdata, we and owner;
  - load `mem_*` registers, with exactly one of the read/write strobes set.
- Winner selection:
  - only one requester pending → that requester wins;
  - both pending → the requester not served last wins (round-robin).
  - `last_owner` resets to I, so the first tie goes to D.
- ACCESS: strobes are high for this cycle only and are cleared at the edge leaving ACCESS. The memory acts on that same edge.
- RESP edge:
  - read → owner's `x_rdata` ← `mem_readData`;
  - write → `x_rdata` unchanged;
  - owner's `x_done` is 1 for the following cycle (the IDLE cycle); `last_owner` updates.
- A requester may drop or change its request fields at any edge after its `x_gnt`. Fields held past `x_gnt` are treated as a new request.
- No gnt is issued outside IDLE. Requests are held and re-arbitrated in IDLE.
- The I port never writes; `mem_writeData` is don't-care for I transactions.

## Timing
- Request accepted at edge e0:
  - strobe visible during e0→e1;
  - `x_done`/`x_rdata` visible during e2→e3.
- Next gnt is possible at edge e3. Peak throughput is one access per 3 cycles.
- Reset values:
  - `state` = IDLE;
  - all strobes, done and err = 0;
  - `x_rdata` = 0, `mem_address` = 0, `mem_writeData` = 0;
  - `last_owner` = I.
- Reset asserted mid-transaction aborts it with no done pulse. A write whose strobe has already been sampled is not undone.
- Both requesters held high continuously → strict alternation D, I, D, I.
- Address arithmetic: pass-through, no wrap handling; range checking is the memory's concern.

## Configuration
- `MEM_ARB_ALIGN_CHECK_EN` defined:
  - accepted requests with `addr[1:0]` ≠ 0 issue no strobe;
  - the FSM still walks ACCESS → RESP;
  - `x_done` pulses with `x_err` = 1 and `x_rdata` unchanged.
- `MEM_ARB_ALIGN_CHECK_EN` undefined:
  - addresses pass through unchecked;
  - `i_err` and `d_err` are tied 0.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the owner encoding (OWN_I = 0, OWN_D = 1);
  - default widths.
- Sub-module `rr_arb2`: combinational two-way round-robin picker with inputs req[1:0] and last and output winner. It is instantiated once.

## Test plan
- Single load: memory word at 0x04 = 0xDEADBEEF; D load from 0x04 → `d_gnt` at e0, `mem_memoryRead` high one cycle, `d_done` high during e2→e3 with `d_rdata` = 0xDEADBEEF.
- Store then fetch: D store 0x12345678 to 0x08, then I fetch from 0x08 → exactly one write strobe, then `i_rdata` = 0x12345678.
- Contention: `i_req` and `d_req` both held for 4 transactions → grant order D, I, D, I, with no done pulse going to the wrong port.
- Reset in ACCESS of a load: `rst_n` low for one edge → no `d_done`, state IDLE, all outputs at their reset values; the held request is re-granted in the cycle after reset is released.
- Alignment, macro on: D load from 0x06 → no strobe, `d_done` = 1 with `d_err` = 1. Macro off: same stimulus → read strobe with address 0x06, `d_err` = 0.
- Back-to-back: `d_req` held with a new address after gnt → second gnt exactly 3 edges after the first.
